// File: rtl/pipe_hazard_scoreboard_if.sv
// Hazard-unit bundle: pipeline stage register fields in, stall/forward controls out.
// The core drives the master side and the scoreboard sits on the slave side.
interface pipe_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
);
    // Decode-stage operand requests
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic [1:0]        d_tuse_rs;
    logic [1:0]        d_tuse_rt;
    logic              d_is_md;

    // Producers and consumers further down the pipe
    logic [REG_AW-1:0] e_rs;
    logic [REG_AW-1:0] e_rt;
    logic [REG_AW-1:0] m_rt;
    logic [REG_AW-1:0] e_wa;
    logic [REG_AW-1:0] m_wa;
    logic [REG_AW-1:0] w_wa;
    logic              e_we;
    logic              m_we;
    logic              w_we;
    logic [1:0]        e_tnew;
    logic [1:0]        m_tnew;
    logic              md_start;
    logic              md_is_div;

    // Pipeline control back to the core
    logic              pc_en;
    logic              fd_en;
    logic              de_clr;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;
    logic              fwd_rt_m;
    logic              md_busy;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        output e_rs, e_rt, m_rt, e_wa, m_wa, w_wa, e_we, m_we, w_we,
        output e_tnew, m_tnew, md_start, md_is_div,
        input  pc_en, fd_en, de_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        input  fwd_rt_m, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        input  e_rs, e_rt, m_rt, e_wa, m_wa, w_wa, e_we, m_we, w_we,
        input  e_tnew, m_tnew, md_start, md_is_div,
        output pc_en, fd_en, de_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        output fwd_rt_m, md_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Five-stage pipeline hazard unit: Tuse/Tnew stall detection, operand forwarding
// selects, multiply/divide occupancy tracking and a saturating stall counter.
module pipe_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4,
    parameter int STAT_W   = 32
) (
    input logic                     clk,
    input logic                     reset_n,
    pipe_hazard_scoreboard_if.slave hz
);

    typedef logic [REG_AW-1:0] reg_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    // A write to r0 is architecturally discarded, so it never produces a hazard.
    function automatic logic hits(input logic we, input reg_t wa, input reg_t r);
        return we && (wa == r) && (r != '0);
    endfunction

    function automatic logic [1:0] sel_d(input logic he, input logic hm, input logic hw,
                                         input logic [1:0] e_tnew, input logic [1:0] m_tnew);
        if (he && (e_tnew == 2'd0))      return 2'd1;
        else if (hm && (m_tnew == 2'd0)) return 2'd2;
        else if (hw)                     return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic hm, input logic hw, input logic [1:0] m_tnew);
        if (hm && (m_tnew == 2'd0)) return 2'd1;
        else if (hw)                return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic late(input logic use_src, input logic he, input logic hm,
                                  input logic [1:0] e_tnew, input logic [1:0] m_tnew,
                                  input logic [1:0] tuse);
        return use_src && ((he && (e_tnew > tuse)) || (hm && (m_tnew > tuse)));
    endfunction

    logic [CNT_W-1:0]  md_cnt_q,    md_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic e_hit_rs_d, m_hit_rs_d, w_hit_rs_d;
    logic e_hit_rt_d, m_hit_rt_d, w_hit_rt_d;
    logic m_hit_rs_e, w_hit_rs_e, m_hit_rt_e, w_hit_rt_e;
    logic w_hit_rt_m;
    logic md_busy;
    logic data_stall, md_stall, stall;

    assign md_busy = (md_cnt_q != '0);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        e_hit_rs_d = hits(hz.e_we, hz.e_wa, hz.d_rs);
        m_hit_rs_d = hits(hz.m_we, hz.m_wa, hz.d_rs);
        w_hit_rs_d = hits(hz.w_we, hz.w_wa, hz.d_rs);
        e_hit_rt_d = hits(hz.e_we, hz.e_wa, hz.d_rt);
        m_hit_rt_d = hits(hz.m_we, hz.m_wa, hz.d_rt);
        w_hit_rt_d = hits(hz.w_we, hz.w_wa, hz.d_rt);
        m_hit_rs_e = hits(hz.m_we, hz.m_wa, hz.e_rs);
        w_hit_rs_e = hits(hz.w_we, hz.w_wa, hz.e_rs);
        m_hit_rt_e = hits(hz.m_we, hz.m_wa, hz.e_rt);
        w_hit_rt_e = hits(hz.w_we, hz.w_wa, hz.e_rt);
        w_hit_rt_m = hits(hz.w_we, hz.w_wa, hz.m_rt);

        data_stall = late(hz.d_use_rs, e_hit_rs_d, m_hit_rs_d, hz.e_tnew, hz.m_tnew, hz.d_tuse_rs)
                   | late(hz.d_use_rt, e_hit_rt_d, m_hit_rt_d, hz.e_tnew, hz.m_tnew, hz.d_tuse_rt);
        // A start in E occupies the unit from this very cycle, before the counter loads.
        md_stall   = hz.d_is_md && (md_busy || hz.md_start);
        stall      = data_stall || md_stall;
    end

    // Forward selects are computed regardless of stall; a bubble in D/E masks them anyway.
    always_comb begin
        hz.pc_en     = !stall;
        hz.fd_en     = !stall;
        hz.de_clr    = stall;
        hz.fwd_rs_d  = sel_d(e_hit_rs_d, m_hit_rs_d, w_hit_rs_d, hz.e_tnew, hz.m_tnew);
        hz.fwd_rt_d  = sel_d(e_hit_rt_d, m_hit_rt_d, w_hit_rt_d, hz.e_tnew, hz.m_tnew);
        hz.fwd_rs_e  = sel_e(m_hit_rs_e, w_hit_rs_e, hz.m_tnew);
        hz.fwd_rt_e  = sel_e(m_hit_rt_e, w_hit_rt_e, hz.m_tnew);
        hz.fwd_rt_m  = w_hit_rt_m;
        hz.md_busy   = md_busy;
        hz.stall_cnt = stall_cnt_q;
    end

    // Starts that arrive while the unit is occupied are dropped, not queued.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q == '0) begin
            if (hz.md_start) begin
                md_cnt_d = hz.md_is_div ? DIV_LOAD : MULT_LOAD;
            end
        end else begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: load-use, branch forwarding, r0,
// MD occupancy, asynchronous reset mid-divide and stall-counter saturation.
module tb_pipe_hazard_scoreboard;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall = 0;

    pipe_hazard_scoreboard_if #(.REG_AW(5), .STAT_W(32)) hz ();
    pipe_hazard_scoreboard_if #(.REG_AW(5), .STAT_W(3))  hz3 ();

    pipe_hazard_scoreboard #(
        .REG_AW(5), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .STAT_W(32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    pipe_hazard_scoreboard #(
        .REG_AW(5), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .STAT_W(3)
    ) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.d_rs = '0;      hz.d_rt = '0;      hz.d_use_rs = 0;   hz.d_use_rt = 0;
        hz.d_tuse_rs = '0; hz.d_tuse_rt = '0; hz.d_is_md = 0;
        hz.e_rs = '0;      hz.e_rt = '0;      hz.m_rt = '0;
        hz.e_wa = '0;      hz.m_wa = '0;      hz.w_wa = '0;
        hz.e_we = 0;       hz.m_we = 0;       hz.w_we = 0;
        hz.e_tnew = '0;    hz.m_tnew = '0;    hz.md_start = 0;   hz.md_is_div = 0;
        hz3.d_rs = '0;     hz3.d_rt = '0;     hz3.d_use_rs = 0;  hz3.d_use_rt = 0;
        hz3.d_tuse_rs = '0; hz3.d_tuse_rt = '0; hz3.d_is_md = 0;
        hz3.e_rs = '0;     hz3.e_rt = '0;     hz3.m_rt = '0;
        hz3.e_wa = '0;     hz3.m_wa = '0;     hz3.w_wa = '0;
        hz3.e_we = 0;      hz3.m_we = 0;      hz3.w_we = 0;
        hz3.e_tnew = '0;   hz3.m_tnew = '0;   hz3.md_start = 0;  hz3.md_is_div = 0;
    endtask

    task automatic load_use();
        hz.e_wa = 5'd8; hz.e_we = 1; hz.e_tnew = 2'd2;
        hz.d_rs = 5'd8; hz.d_use_rs = 1; hz.d_tuse_rs = 2'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;

        // Reset state, and combinational behaviour while reset is held
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_md_busy", hz.md_busy, 0);
        check("rst_stall_cnt", hz.stall_cnt, 0);
        check("rst_pc_en", hz.pc_en, 1);
        check("rst_de_clr", hz.de_clr, 0);
        load_use();
        #1;
        check("rst_comb_de_clr", hz.de_clr, 1);
        step();
        check("rst_no_count", hz.stall_cnt, 0);
        clear_inputs();
        reset_n = 1'b1;
        step();
        check("post_rst_cnt", hz.stall_cnt, 0);

        // Load-use: E produces r8 in two cycles, D needs it in one
        load_use();
        #1;
        check("lu_pc_en", hz.pc_en, 0);
        check("lu_fd_en", hz.fd_en, 0);
        check("lu_de_clr", hz.de_clr, 1);
        check("lu_fwd_rs_d", hz.fwd_rs_d, 0);
        step();
        exp_stall++;
        check("lu_stall_cnt", hz.stall_cnt, exp_stall);
        hz.d_tuse_rs = 2'd2;
        #1;
        check("lu_tuse_eq", hz.pc_en, 1);
        hz.d_tuse_rs = 2'd1; hz.d_use_rs = 0;
        #1;
        check("lu_unused", hz.de_clr, 0);

        // Branch operand: forward from M; an E producer with tnew=1 then stalls
        clear_inputs();
        hz.m_wa = 5'd9; hz.m_we = 1; hz.m_tnew = 2'd0;
        hz.d_rt = 5'd9; hz.d_use_rt = 1; hz.d_tuse_rt = 2'd0;
        #1;
        check("br_fwd_m", hz.fwd_rt_d, 2);
        check("br_no_stall", hz.pc_en, 1);
        hz.e_wa = 5'd9; hz.e_we = 1; hz.e_tnew = 2'd1;
        #1;
        check("br_e_stall", hz.de_clr, 1);
        check("br_fwd_indep", hz.fwd_rt_d, 2);
        step();
        exp_stall++;
        check("br_stall_cnt", hz.stall_cnt, exp_stall);
        hz.e_tnew = 2'd0;
        #1;
        check("br_fwd_e_prio", hz.fwd_rt_d, 1);
        check("br_e_ready", hz.pc_en, 1);
        hz.e_we = 0; hz.m_we = 0; hz.w_wa = 5'd9; hz.w_we = 1;
        #1;
        check("br_fwd_w", hz.fwd_rt_d, 3);

        // E and M stage forwarding
        clear_inputs();
        hz.e_rs = 5'd5; hz.e_rt = 5'd6; hz.m_rt = 5'd5;
        hz.m_wa = 5'd5; hz.m_we = 1; hz.m_tnew = 2'd0;
        hz.w_wa = 5'd5; hz.w_we = 1;
        #1;
        check("e_fwd_m", hz.fwd_rs_e, 1);
        check("e_fwd_none", hz.fwd_rt_e, 0);
        check("m_fwd_w", hz.fwd_rt_m, 1);
        hz.m_tnew = 2'd1;
        #1;
        check("e_fwd_w", hz.fwd_rs_e, 2);

        // r0 is never a hazard nor a forward source
        clear_inputs();
        hz.e_we = 1; hz.m_we = 1; hz.w_we = 1; hz.e_tnew = 2'd2; hz.m_tnew = 2'd2;
        hz.d_use_rs = 1; hz.d_use_rt = 1;
        #1;
        check("r0_fwd_rs_d", hz.fwd_rs_d, 0);
        check("r0_fwd_rt_d", hz.fwd_rt_d, 0);
        check("r0_fwd_rs_e", hz.fwd_rs_e, 0);
        check("r0_fwd_rt_m", hz.fwd_rt_m, 0);
        check("r0_no_stall", hz.pc_en, 1);

        // Divide: start cycle plus ten busy cycles all stall an MD instruction in D
        clear_inputs();
        hz.md_start = 1; hz.md_is_div = 1; hz.d_is_md = 1;
        #1;
        check("div_start_busy", hz.md_busy, 0);
        check("div_start_stall", hz.de_clr, 1);
        step();
        exp_stall++;
        hz.md_start = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("div_busy_%0d", i), hz.md_busy, 1);
            check($sformatf("div_stall_%0d", i), hz.de_clr, 1);
            step();
            exp_stall++;
        end
        check("div_done", hz.md_busy, 0);
        check("div_no_stall", hz.de_clr, 0);
        check("div_stall_cnt", hz.stall_cnt, exp_stall);

        // Multiply with a start pulse while busy, which must be ignored
        clear_inputs();
        hz.md_start = 1;
        step();
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            hz.md_start = (i == 1);
            hz.md_is_div = (i == 1);
            #1;
            if (hz.md_busy) busy++;
            step();
        end
        check("mul_retrig_busy", busy, 5);
        check("mul_no_stall", hz.stall_cnt, exp_stall);

        // Asynchronous reset in the fourth busy cycle of a divide
        clear_inputs();
        hz.md_start = 1; hz.md_is_div = 1;
        step();
        hz.md_start = 0;
        step(); step(); step();
        check("mid_div_busy", hz.md_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_md_busy", hz.md_busy, 0);
        check("async_stall_cnt", hz.stall_cnt, 0);
        exp_stall = 0;
        step();
        reset_n = 1'b1;
        hz.md_start = 1; hz.md_is_div = 0;
        step();
        hz.md_start = 0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (hz.md_busy) busy++;
            step();
        end
        check("post_rst_mul_busy", busy, 5);
        check("post_rst_stall_cnt", hz.stall_cnt, exp_stall);

        // Three-bit counter saturates at 7 over ten stall cycles
        clear_inputs();
        hz3.e_wa = 5'd8; hz3.e_we = 1; hz3.e_tnew = 2'd2;
        hz3.d_rs = 5'd8; hz3.d_use_rs = 1; hz3.d_tuse_rs = 2'd1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("sat_%0d", i), hz3.stall_cnt, (i > 7) ? 7 : i);
        end
        check("sat_main_idle", hz.stall_cnt, exp_stall);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_scoreboard.md
PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter MULT_CYC, default 5: multiply busy cycles, 1..2^CNT_W-1.
REQ-003 SHALL have parameter DIV_CYC, default 10: divide busy cycles, 1..2^CNT_W-1.
REQ-004 SHALL have parameter CNT_W, default 4: MD counter width.
REQ-005 SHALL have parameter STAT_W, default 32: stall statistic width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 d_rs, d_rt  in  REG_AW each  D-stage source registers.
REQ-009 d_use_rs, d_use_rt  in  1 each  D-stage source is read.
REQ-010 d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs operand (0 = in D).
REQ-011 d_is_md  in  1  D instruction accesses HI/LO or the MD unit.
REQ-012 e_rs, e_rt  in  REG_AW each  E-stage sources; m_rt  in  REG_AW  M-stage store source.
REQ-013 e_wa, m_wa, w_wa  in  REG_AW each  destination register per stage.
REQ-014 e_we, m_we, w_we  in  1 each  stage will write the register file.
REQ-015 e_tnew, m_tnew  in  2 each  remaining cycles until the stage's result exists (0 = ready now).
REQ-016 md_start  in  1  E-stage MD start pulse; md_is_div  in  1  1 = divide, 0 = multiply.
REQ-017 pc_en, fd_en  out  1 each  PC and F/D register enables.
REQ-018 de_clr  out  1  inserts a bubble into D/E.
REQ-019 fwd_rs_d, fwd_rt_d  out  2 each  0 = regfile, 1 = E, 2 = M, 3 = W.
REQ-020 fwd_rs_e, fwd_rt_e  out  2 each  0 = pipe value, 1 = M, 2 = W.
REQ-021 fwd_rt_m  out  1  0 = pipe value, 1 = W.
REQ-022 md_busy  out  1  MD unit occupied; stall_cnt  out  STAT_W  total stalled cycles.

Function
REQ-023 A stage "hits" register r when its we=1, its wa==r and r!=0.
REQ-024 D forward: highest-priority hit among E (only if e_tnew==0), then M (only if m_tnew==0), then W; otherwise 0.
REQ-025 E forward: M hit with m_tnew==0 -> 1, else W hit -> 2, else 0; M forward: W hit on m_rt -> 1, else 0.
REQ-026 Data stall when a used D source is hit by E with e_tnew>tuse, or by M with m_tnew>tuse, for that source.
REQ-027 MD stall when d_is_md and (md_busy or md_start).
REQ-028 stall = data stall OR MD stall; pc_en = fd_en = !stall and de_clr = stall, all combinational in the same cycle.
REQ-029 MD counter: md_start while counter==0 loads MULT_CYC or DIV_CYC per md_is_div; otherwise it decrements to 0 and holds.
REQ-030 md_busy = (counter!=0); md_start while counter!=0 is ignored and the counter is unchanged.
REQ-031 stall_cnt increments by 1 per clock with stall=1 and saturates at all-ones with no wrap.
REQ-032 Forwarding outputs are independent of stall; de_clr does not alter them.

Reset
REQ-033 reset_n=0 asynchronously clears the MD counter and stall_cnt; md_busy=0 immediately.
REQ-034 During reset, outputs remain combinational on inputs with md_busy=0; reset during a busy MD operation aborts it.
REQ-035 The first edge after reset_n rises obeys REQ-029..031 normally.

Verification
REQ-036 Load-use: e_wa=8, e_we=1, e_tnew=2, d_rs=8, d_use_rs=1, d_tuse_rs=1 -> pc_en=0, de_clr=1, stall_cnt +1.
REQ-037 Branch: m_wa=9, m_tnew=0, d_rt=9, d_tuse_rt=0 -> fwd_rt_d=2, no stall; repeat with e_wa=9, e_tnew=1 -> stall.
REQ-038 $0: all stages write r0 with d_rs=0 -> all fwd=0 and no stall.
REQ-039 MD: md_start=1, md_is_div=1 -> md_busy high for exactly DIV_CYC=10 cycles; d_is_md=1 stalls each of them plus the start cycle.
REQ-040 Reset mid-divide at cycle 4 -> md_busy=0 without waiting for an edge, stall_cnt=0; a new multiply afterwards is busy for 5 cycles.
REQ-041 Saturation: STAT_W=3 with 10 stall cycles -> stall_cnt holds 7.
